i2c_master_byte_ctrl: RTL
=========================

I2C_MASTER_BYTE_CTRL -- requirements
Module: i2c_master_byte_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, payload byte width; only 8 is supported.
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  one-cycle request; sampled only in IDLE.
REQ-005 SHALL have port rw  input  1  0 = write, 1 = read; captured with start.
REQ-006 SHALL have port addr  input  7  slave address; captured with start.
REQ-007 SHALL have port wdata  input  8  write byte; captured with start.
REQ-008 SHALL have port tick  input  1  one-cycle phase strobe from the I2C clock divider.
REQ-009 SHALL have port en_clk  output  1  divider enable; high exactly while busy.
REQ-010 SHALL have port scl_oe  output  1  1 = pull SCL low, 0 = release.
REQ-011 SHALL have port sda_oe  output  1  1 = pull SDA low, 0 = release.
REQ-012 SHALL have port sda_i  input  1  sampled SDA line level.
REQ-013 SHALL have ports busy, done, ack_err  output  1 each  status; done is a one-cycle pulse.
REQ-014 SHALL have port rdata  output  8  last byte read.

Function
REQ-015 Bit timing: every I2C bit SHALL last 4 ticks, with phase counter 0..3 advancing only on tick and wrapping 3->0.
REQ-016 Data/ACK bit phases SHALL be: ph0 SCL low and SDA updated; ph1 SCL released; ph2 SDA sampled while SCL high; ph3 SCL low.
REQ-017 FSM states SHALL be IDLE, START, ADDR, ACK_A, DATA, ACK_D, STOP.
REQ-018 IDLE + start SHALL capture {addr, rw, wdata}, set busy and en_clk next cycle, clear ack_err, and enter START.
REQ-019 In START, SDA SHALL be released at ph0-1, pulled low at ph2 with SCL released, and SCL pulled low at ph3; then the FSM enters ADDR.
REQ-020 ADDR SHALL shift out {addr, rw} MSB first over 8 bits, then the FSM enters ACK_A.
REQ-021 ACK_A SHALL release SDA, sample sda_i at ph2 (0 = ACK), and on NACK set ack_err and go to STOP, otherwise go to DATA.
REQ-022 DATA with rw=0 SHALL drive wdata MSB first; with rw=1 SHALL release SDA and shift sda_i in at ph2, MSB first.
REQ-023 ACK_D on write SHALL sample the slave ACK with NACK setting ack_err; on read the master SHALL drive NACK (SDA released), and rdata SHALL be updated at ph0 of ACK_D.
REQ-024 In STOP, ph0 SHALL pull SDA low with SCL low, ph1 release SCL, ph2 release SDA, and ph3 hold both lines released.
REQ-025 After STOP ph3, done SHALL pulse for 1 cycle, busy and en_clk SHALL drop in the same cycle, and the FSM returns to IDLE.
REQ-026 A full transaction SHALL take exactly 80 ticks; an address-NACK transaction SHALL take exactly 44 ticks.
REQ-027 start while busy SHALL be ignored with no capture.
REQ-028 A tick with en_clk low SHALL be ignored.
REQ-029 Outputs SHALL be registered; line changes occur the cycle after the tick.
REQ-030 ack_err and rdata SHALL hold until the next accepted start; rdata is unchanged on an address NACK.

Reset
REQ-031 Assertion of rst_n SHALL immediately force IDLE, phase 0, scl_oe=0, sda_oe=0, en_clk=0, busy=0, done=0, ack_err=0, rdata=0.
REQ-032 Reset mid-transaction SHALL release both lines with no STOP generated and no done pulse.

Structure
REQ-033 Package i2c_pkg SHALL hold the state enum i2c_state_t, phase constants PH_LOW/PH_RISE/PH_SAMPLE/PH_FALL, and BITS_PER_BYTE=8.
REQ-034 Sub-module i2c_shift8 SHALL implement the 8-bit load/shift-out/shift-in register with bit counter; the FSM stays in the top.

Verification
REQ-035 Write addr=7'h50, wdata=8'hA5, slave ACKs both -> SDA bits 1010000_0 and 10100101, done after 80 ticks, ack_err=0.
REQ-036 Read addr=7'h3C, slave drives 8'h5A -> rdata=8'h5A, master NACK on bit 9, done, ack_err=0.
REQ-037 Write addr=7'h11 with no slave ACK -> ack_err=1, STOP right after ACK_A, done after 44 ticks, rdata unchanged.
REQ-038 start pulsed again at tick 20 of a transaction -> ignored; captured fields unchanged; exactly one done pulse.
REQ-039 rst_n low at tick 40 -> all outputs at reset values within the same cycle, both lines released, no done pulse; a new start afterwards completes normally.
REQ-040 Protocol checker on every run: SDA changes only while SCL is low, except during the START and STOP edges.

Source files
------------

// File: rtl/i2c_pkg.sv
// i2c_pkg
// Shared definitions for the I2C byte-level master:
//   i2c_state_t   - transaction FSM states
//   PH_*          - the four phases that make up one I2C bit
//   BITS_PER_BYTE - payload bits per transferred byte
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_ACK_A,
        ST_DATA,
        ST_ACK_D,
        ST_STOP
    } i2c_state_t;

    localparam logic [1:0] PH_LOW    = 2'd0;
    localparam logic [1:0] PH_RISE   = 2'd1;
    localparam logic [1:0] PH_SAMPLE = 2'd2;
    localparam logic [1:0] PH_FALL   = 2'd3;

    localparam int BITS_PER_BYTE = 8;

endpackage

// File: rtl/i2c_shift8.sv
// i2c_shift8
// 8-bit shift register with bit counter shared by the address and data bytes.
// Ports:
//   clk, rst_n          - clock, async active-low reset
//   load, load_data     - parallel load; also clears the bit counter
//   shift, shift_in     - shift left one bit, shift_in enters at the LSB
//   data                - register contents (data[7] is the bit being sent)
//   byte_done           - all 8 bits of the current byte have been shifted
module i2c_shift8
    import i2c_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load,
    input  logic [BITS_PER_BYTE-1:0] load_data,
    input  logic                     shift,
    input  logic                     shift_in,
    output logic [BITS_PER_BYTE-1:0] data,
    output logic                     byte_done
);

    logic [3:0] bit_cnt;

    assign byte_done = (bit_cnt == 4'(BITS_PER_BYTE));

    // Shifting once per bit in the sample phase serves both directions:
    // outgoing bits were already registered onto SDA at the low phase, and
    // incoming bits are captured from the line at the same moment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data    <= '0;
            bit_cnt <= '0;
        end else if (load) begin
            data    <= load_data;
            bit_cnt <= '0;
        end else if (shift) begin
            data    <= {data[BITS_PER_BYTE-2:0], shift_in};
            bit_cnt <= bit_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/i2c_master_byte_ctrl.sv
// i2c_master_byte_ctrl
// Single-byte I2C master: START, 7-bit address + R/W, slave ACK, one data
// byte (write or read), ACK/NACK, STOP. Each bit is four divider ticks.
// Ports:
//   clk, rst_n           - clock, async active-low reset
//   start, rw, addr, wdata - transaction request, captured in IDLE only
//   tick                 - phase strobe from the I2C clock divider
//   en_clk               - divider enable, high while busy
//   scl_oe, sda_oe       - open-drain pull-downs (1 = drive line low)
//   sda_i                - sampled SDA line
//   busy, done, ack_err  - status; done pulses one cycle at the end
//   rdata                - last byte read
module i2c_master_byte_ctrl
    import i2c_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              rw,
    input  logic [6:0]        addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              tick,
    output logic              en_clk,
    output logic              scl_oe,
    output logic              sda_oe,
    input  logic              sda_i,
    output logic              busy,
    output logic              done,
    output logic              ack_err,
    output logic [DATA_W-1:0] rdata
);

    i2c_state_t         state;
    logic [1:0]         phase;
    logic [6:0]         addr_q;
    logic               rw_q;
    logic [DATA_W-1:0]  wdata_q;

    logic                     tick_en;
    logic                     sh_load;
    logic                     sh_shift;
    logic [BITS_PER_BYTE-1:0] sh_load_data;
    logic [BITS_PER_BYTE-1:0] sh_data;
    logic                     sh_byte_done;

    // Ticks only count while the divider is enabled.
    assign tick_en = tick & en_clk;

    // The address byte is loaded as START finishes, the data byte as the
    // address ACK finishes (harmless when a NACK sends us to STOP instead).
    always_comb begin
        sh_load      = 1'b0;
        sh_shift     = 1'b0;
        sh_load_data = wdata_q;
        if (tick_en) begin
            case (state)
                ST_START: begin
                    if (phase == PH_FALL) begin
                        sh_load      = 1'b1;
                        sh_load_data = {addr_q, rw_q};
                    end
                end
                ST_ADDR, ST_DATA: begin
                    if (phase == PH_SAMPLE) sh_shift = 1'b1;
                end
                ST_ACK_A: begin
                    if (phase == PH_FALL) sh_load = 1'b1;
                end
                default: ;
            endcase
        end
    end

    i2c_shift8 u_shift (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (sh_load),
        .load_data (sh_load_data),
        .shift     (sh_shift),
        .shift_in  (sda_i),
        .data      (sh_data),
        .byte_done (sh_byte_done)
    );

    // Transaction FSM. Each tick performs the action of the current phase and
    // advances the phase; the last phase of a bit also decides the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            phase   <= PH_LOW;
            scl_oe  <= 1'b0;
            sda_oe  <= 1'b0;
            en_clk  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ack_err <= 1'b0;
            rdata   <= '0;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            done <= 1'b0;
            if (state == ST_IDLE) begin
                if (start) begin
                    addr_q  <= addr;
                    rw_q    <= rw;
                    wdata_q <= wdata;
                    busy    <= 1'b1;
                    en_clk  <= 1'b1;
                    ack_err <= 1'b0;
                    phase   <= PH_LOW;
                    state   <= ST_START;
                end
            end else if (tick_en) begin
                phase <= phase + 2'd1;
                case (state)
                    ST_START: begin
                        case (phase)
                            PH_SAMPLE: sda_oe <= 1'b1;
                            PH_FALL: begin
                                scl_oe <= 1'b1;
                                state  <= ST_ADDR;
                            end
                            default: begin
                                scl_oe <= 1'b0;
                                sda_oe <= 1'b0;
                            end
                        endcase
                    end
                    ST_ADDR, ST_DATA: begin
                        case (phase)
                            PH_LOW: begin
                                scl_oe <= 1'b1;
                                // A read releases SDA so the slave can drive it.
                                sda_oe <= (state == ST_DATA && rw_q) ? 1'b0
                                                                     : ~sh_data[BITS_PER_BYTE-1];
                            end
                            PH_RISE: scl_oe <= 1'b0;
                            PH_FALL: begin
                                scl_oe <= 1'b1;
                                if (sh_byte_done)
                                    state <= (state == ST_ADDR) ? ST_ACK_A : ST_ACK_D;
                            end
                            default: ;
                        endcase
                    end
                    ST_ACK_A: begin
                        case (phase)
                            PH_LOW: begin
                                scl_oe <= 1'b1;
                                sda_oe <= 1'b0;
                            end
                            PH_RISE:   scl_oe <= 1'b0;
                            PH_SAMPLE: if (sda_i) ack_err <= 1'b1;
                            default: begin
                                scl_oe <= 1'b1;
                                state  <= ack_err ? ST_STOP : ST_DATA;
                            end
                        endcase
                    end
                    ST_ACK_D: begin
                        case (phase)
                            PH_LOW: begin
                                // On a read the released SDA is the master's NACK.
                                scl_oe <= 1'b1;
                                sda_oe <= 1'b0;
                                if (rw_q) rdata <= sh_data;
                            end
                            PH_RISE:   scl_oe <= 1'b0;
                            PH_SAMPLE: if (!rw_q && sda_i) ack_err <= 1'b1;
                            default: begin
                                scl_oe <= 1'b1;
                                state  <= ST_STOP;
                            end
                        endcase
                    end
                    ST_STOP: begin
                        case (phase)
                            PH_LOW: begin
                                scl_oe <= 1'b1;
                                sda_oe <= 1'b1;
                            end
                            PH_RISE:   scl_oe <= 1'b0;
                            PH_SAMPLE: sda_oe <= 1'b0;
                            default: begin
                                scl_oe <= 1'b0;
                                sda_oe <= 1'b0;
                                busy   <= 1'b0;
                                en_clk <= 1'b0;
                                done   <= 1'b1;
                                state  <= ST_IDLE;
                            end
                        endcase
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
